// File: rtl/mac_div128.sv
`default_nettype none
// ============================================================================
//  Module   : mac_div128
//  Purpose  : Iterative radix-2 restoring divider. Divides a 2*DW-bit
//             accumulator value by a DW-bit divisor, one quotient bit per
//             clock, returning quotient and remainder (acc = q*divisor + r).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1      rising-edge clock
//    rst_n        in   1      asynchronous active-low reset
//    in_valid     in   1      dividend/divisor present
//    in_ready     out  1      block can accept a new operation
//    dividend     in   2*DW   accumulator value to divide (unsigned)
//    divisor      in   DW     divisor (unsigned)
//    out_valid    out  1      result present
//    out_ready    in   1      consumer accepts result
//    quotient     out  2*DW   unsigned quotient
//    remainder    out  DW     unsigned remainder
//    div_by_zero  out  1      result belongs to a zero-divisor operation
// ============================================================================
module mac_div128 #(
  parameter int DW = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*DW-1:0]   dividend,
  input  logic [DW-1:0]     divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*DW-1:0]   quotient,
  output logic [DW-1:0]     remainder,
  output logic              div_by_zero
);

  localparam int CW = $clog2(2*DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  // Dividend shift register; quotient bits are shifted in at the bottom as
  // dividend bits leave the top, so it holds the quotient after 2*DW steps.
  logic [2*DW-1:0] sr;
  logic [DW-1:0]   dvs;
  // The partial remainder is always < divisor between steps, so DW bits are
  // enough to store it; only the shifted trial value needs DW+1 bits.
  logic [DW-1:0]   pr;
  logic [CW-1:0]   cnt;

  logic [DW:0]     shifted;
  logic            ge;
  logic [DW-1:0]   diff_lo;
  logic [DW-1:0]   pr_next;
  logic            last;

  always_comb begin
    shifted = {pr, sr[2*DW-1]};
    ge      = (shifted >= {1'b0, dvs});
    // When ge holds the true difference is < divisor, so the low DW bits
    // of the modular subtraction are exact.
    diff_lo = shifted[DW-1:0] - dvs;
    pr_next = ge ? diff_lo : shifted[DW-1:0];
    last    = (cnt == CW'(2*DW-1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      sr          <= '0;
      dvs         <= '0;
      pr          <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sr       <= dividend;
            dvs      <= divisor;
            pr       <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= (divisor == '0) ? DONE : CALC;
          end
        end

        CALC: begin
          pr  <= pr_next;
          sr  <= {sr[2*DW-2:0], ge};
          cnt <= cnt + 1'b1;
          if (last) begin
            quotient    <= {sr[2*DW-2:0], ge};
            remainder   <= pr_next;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end

        DONE: begin
          if (!out_valid) begin
            // Only a zero-divisor operation arrives here with out_valid low:
            // publish the saturated result one cycle after acceptance.
            quotient    <= '1;
            remainder   <= sr[DW-1:0];
            div_by_zero <= 1'b1;
            out_valid   <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_div128.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_div128
//  Purpose  : Directed self-checking bench for mac_div128 (DW = 64).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mac_div128;

  localparam int DW = 64;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2*DW-1:0]   dividend;
  logic [DW-1:0]     divisor;
  logic              out_valid;
  logic              out_ready;
  logic [2*DW-1:0]   quotient;
  logic [DW-1:0]     remainder;
  logic              div_by_zero;

  int total;
  int bad;

  mac_div128 #(.DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present an operation before an edge, let it be accepted, then count the
  // edges until out_valid appears while confirming in_ready stays low.
  task automatic start_and_wait(input string tag, input logic [127:0] a,
                                input logic [63:0] b, input int exp_lat);
    int n;
    bit ready_ok;
    @(negedge clk);
    check({tag, "_in_ready_before"}, 128'(in_ready), 128'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);           // accept edge E0
    #1;
    in_valid = 1'b0;
    dividend = '0;            // block must keep its own copy
    divisor  = '0;
    check({tag, "_in_ready_after_accept"}, 128'(in_ready), 128'd0);
    n = 0;
    ready_ok = 1'b1;
    while (!out_valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (in_ready) ready_ok = 1'b0;
    end
    check({tag, "_latency"}, 128'(n), 128'(exp_lat));
    check({tag, "_in_ready_low_while_busy"}, 128'(ready_ok), 128'd1);
  endtask

  task automatic check_result(input string tag, input logic [127:0] q,
                              input logic [63:0] r, input logic dz);
    check({tag, "_out_valid"}, 128'(out_valid), 128'd1);
    check({tag, "_quotient"}, quotient, q);
    check({tag, "_remainder"}, 128'(remainder), 128'(r));
    check({tag, "_div_by_zero"}, 128'(div_by_zero), 128'(dz));
  endtask

  task automatic retire(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_out_valid_cleared"}, 128'(out_valid), 128'd0);
    check({tag, "_in_ready_restored"}, 128'(in_ready), 128'd1);
  endtask

  task automatic run_op(input string tag, input logic [127:0] a, input logic [63:0] b,
                        input int lat, input logic [127:0] q, input logic [63:0] r,
                        input logic dz);
    start_and_wait(tag, a, b, lat);
    check_result(tag, q, r, dz);
    retire(tag);
  endtask

  initial begin
    logic [127:0] held_q;
    logic [63:0]  held_r;
    bit           hold_ok;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_quotient", quotient, 128'd0);
    check("rst_remainder", 128'(remainder), 128'd0);
    check("rst_div_by_zero", 128'(div_by_zero), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic
    run_op("basic", 128'd26, 64'd7, 128, 128'd3, 64'd5, 1'b0);

    // Inverse of MAC: (2^64-1)*(2^64-1) + (2^64-2)
    run_op("mac_inv", 128'hFFFFFFFFFFFFFFFE_FFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 128,
           128'h0000000000000000_FFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 1'b0);

    // Extremes
    run_op("div_one", {128{1'b1}}, 64'd1, 128, {128{1'b1}}, 64'd0, 1'b0);
    run_op("big_divisor", 128'd5, 64'hFFFFFFFFFFFFFFFF, 128, 128'd0, 64'd5, 1'b0);
    run_op("zero_dividend", 128'd0, 64'd13, 128, 128'd0, 64'd0, 1'b0);

    // Divide by zero
    run_op("div0", 128'h1234_0000000000000ABC, 64'd0, 1, {128{1'b1}}, 64'hABC, 1'b1);

    // Non-zero result after a zero-divisor one must clear the flag
    run_op("after_div0", 128'd1000, 64'd7, 128, 128'd142, 64'd6, 1'b0);

    // Backpressure: hold result while in_valid toggles with new operands
    start_and_wait("bp", 128'd12345, 64'd100, 128);
    check_result("bp", 128'd123, 64'd45, 1'b0);
    held_q  = quotient;
    held_r  = remainder;
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      dividend = 128'd777 + 128'(i);
      divisor  = 64'd0;
      @(posedge clk);
      #1;
      if (!(out_valid === 1'b1 && in_ready === 1'b0 && quotient === held_q &&
            remainder === held_r && div_by_zero === 1'b0)) hold_ok = 1'b0;
    end
    check("bp_outputs_held", 128'(hold_ok), 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
    retire("bp");
    run_op("bp_next", 128'd50, 64'd3, 128, 128'd16, 64'd2, 1'b0);

    // Reset in the middle of CALC
    start_and_wait("pre_rst", 128'd999, 64'd10, 128);
    check_result("pre_rst", 128'd99, 64'd9, 1'b0);
    retire("pre_rst");
    @(negedge clk);
    dividend = 128'd1_000_000;
    divisor  = 64'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_quotient", quotient, 128'd0);
    check("midrst_remainder", 128'(remainder), 128'd0);
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    check("midrst_div_by_zero", 128'(div_by_zero), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 128'd100, 64'd9, 128, 128'd11, 64'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
